// File: rtl/mul_pipe_pkg.sv
// Shared constants and the stage payload type for the pipelined multiplier.
// The defaults here match the team's classic 32-bit multiplier configuration.
package mul_pipe_pkg;

  localparam int MP_WIDTH  = 32;
  localparam int MP_STAGES = 4;
  localparam int MP_TAG_W  = 4;
  localparam int CHUNK_W   = MP_WIDTH / MP_STAGES;

  // Payload carried between pipeline stages for the default configuration.
  typedef struct packed {
    logic                  valid;
    logic                  sign;
    logic                  smode;
    logic [MP_WIDTH-1:0]   a_abs;
    logic [MP_WIDTH-1:0]   b_rem;
    logic [2*MP_WIDTH-1:0] acc;
    logic [MP_TAG_W-1:0]   tag;
  } stage_t;

  function automatic int chunk_of(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/mul_pp_stage.sv
// One partial-product accumulation stage: adds |a| times the lowest remaining
// chunk of |b| (shifted into place) to the accumulator, then retires that chunk.
module mul_pp_stage
  import mul_pipe_pkg::*;
#(
  parameter int  WIDTH     = MP_WIDTH,
  parameter int  CW        = CHUNK_W,
  parameter int  SHIFT     = 0,
  parameter type payload_t = stage_t
) (
  input  logic     CLK,
  input  logic     rst_n,
  input  logic     advance,
  input  payload_t i_pld,
  output payload_t o_pld
);

  localparam int ACC_W = 2 * WIDTH;

  logic [ACC_W-1:0] w_pp;
  payload_t         w_next;
  payload_t         r_pld;

  // NOTE: every variable gets a full default at the top of always_comb so no latch can form.
  always_comb begin
    w_pp         = ACC_W'(i_pld.a_abs) * ACC_W'(i_pld.b_rem[CW-1:0]);
    w_next       = i_pld;
    w_next.acc   = i_pld.acc + (w_pp << SHIFT);
    w_next.b_rem = i_pld.b_rem >> CW;
  end

  // NOTE: only the valid bit is reset; payload data in an empty slot is never observed.
  // NOTE: state is updated with non-blocking assignments so all stages shift together.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_pld.valid <= 1'b0;
    end else if (advance) begin
      r_pld <= w_next;
    end
  end

  assign o_pld = r_pld;

endmodule

// File: rtl/mul_pipe.sv
// Fully pipelined signed/unsigned multiplier with valid/ready on both sides.
// Capture -> STAGES accumulation stages -> result stage -> output register.
module mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int WIDTH  = MP_WIDTH,
  parameter int STAGES = MP_STAGES,
  parameter int TAG_W  = MP_TAG_W
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW    = chunk_of(WIDTH, STAGES);
  localparam int ACC_W = 2 * WIDTH;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("mul_pipe: WIDTH must be a multiple of STAGES and STAGES must be >= 1");
  end

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic             smode;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_rem;
    logic [ACC_W-1:0] acc;
    logic [TAG_W-1:0] tag;
  } payload_t;

  logic             w_advance;
  logic             w_a_neg;
  logic             w_b_neg;
  payload_t         w_cap;
  payload_t         r_cap;
  payload_t         w_stage [STAGES+1];
  logic [ACC_W-1:0] w_prod;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic             w_ovf;
  logic             r_res_valid;
  logic             r_res_ovf;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic [TAG_W-1:0] r_res_tag;
  logic             w_busy;

  // A single global stall: the whole pipe moves only when the output slot frees up.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance && rst_n;

  // Magnitudes are exact for the most negative value: -(2^(W-1)) wraps to 2^(W-1) unsigned.
  always_comb begin
    w_a_neg     = in_signed & in_a[WIDTH-1];
    w_b_neg     = in_signed & in_b[WIDTH-1];
    w_cap       = '0;
    w_cap.valid = in_valid;
    w_cap.sign  = w_a_neg ^ w_b_neg;
    w_cap.smode = in_signed;
    w_cap.a_abs = w_a_neg ? -in_a : in_a;
    w_cap.b_rem = w_b_neg ? -in_b : in_b;
    w_cap.tag   = in_tag;
  end

  assign w_stage[0] = r_cap;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    mul_pp_stage #(
      .WIDTH    (WIDTH),
      .CW       (CW),
      .SHIFT    (i * CW),
      .payload_t(payload_t)
    ) u_stage (
      .CLK    (CLK),
      .rst_n  (rst_n),
      .advance(w_advance),
      .i_pld  (w_stage[i]),
      .o_pld  (w_stage[i+1])
    );
  end

  always_comb begin
    w_prod = w_stage[STAGES].sign ? -w_stage[STAGES].acc : w_stage[STAGES].acc;
    w_lo   = w_prod[WIDTH-1:0];
    w_hi   = w_prod[ACC_W-1:WIDTH];
    w_ovf  = w_stage[STAGES].smode ? (w_hi != {WIDTH{w_lo[WIDTH-1]}}) : (w_hi != '0);
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_cap.valid <= 1'b0;
      r_res_valid <= 1'b0;
      out_valid   <= 1'b0;
      out_lo      <= '0;
      out_hi      <= '0;
      out_ovf     <= 1'b0;
      out_tag     <= '0;
    end else if (w_advance) begin
      r_cap       <= w_cap;
      r_res_valid <= w_stage[STAGES].valid;
      if (w_stage[STAGES].valid) begin
        r_res_lo  <= w_lo;
        r_res_hi  <= w_hi;
        r_res_ovf <= w_ovf;
        r_res_tag <= w_stage[STAGES].tag;
      end
      out_valid <= r_res_valid;
      if (r_res_valid) begin
        out_lo  <= r_res_lo;
        out_hi  <= r_res_hi;
        out_ovf <= r_res_ovf;
        out_tag <= r_res_tag;
      end
    end
  end

  always_comb begin
    w_busy = r_cap.valid | r_res_valid | out_valid;
    for (int i = 1; i <= STAGES; i++) begin
      w_busy = w_busy | w_stage[i].valid;
    end
  end

  assign busy = w_busy;

endmodule
